// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, branch redirect and decode.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  imm_src;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, imm_src,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, imm_src,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response FIFO with
// immediate-format pre-decode, and flush/restart on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];

  logic          running;
  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [31:0]   redirect_target;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic [1:0]    unused_bits;

  assign unused_bits = bus.redirect_pc[1:0];

  function automatic logic [2:0] imm_dec(input logic [6:0] opc);
    logic [2:0] sel;
    sel = 3'b000;
    case (opc)
      7'b0100011:             sel = 3'b001;
      7'b1100011:             sel = 3'b010;
      7'b0110111, 7'b0010111: sel = 3'b011;
      7'b1101111:             sel = 3'b100;
      default:                sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Fetch starts one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    running = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  running = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every in-flight request, stale or not, holds a reserved FIFO slot.
  always_comb begin
    credit_ok       = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
    req_valid       = running && credit_ok;
    req_fire        = req_valid && bus.imem_req_ready;
    head_valid      = (count_q != '0);
    rsp_drop        = bus.imem_rsp_valid && (discard_q != '0);
    push            = bus.imem_rsp_valid && !rsp_drop && !bus.redirect_valid;
    pop             = head_valid && bus.instr_ready;
    redirect_target = {bus.redirect_pc[31:2], 2'b00};
    outstanding_d   = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);

    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    discard_d = discard_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      pc_d      = redirect_target;
      rsp_pc_d  = redirect_target;
      discard_d = outstanding_d;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop)      rd_ptr_d  = rd_ptr_q + AW'(1);
      if (rsp_drop) discard_d = discard_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind head_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
      mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  assign head_instr = mem_instr_q[rd_ptr_q];
  assign head_pc    = mem_pc_q[rd_ptr_q];

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = head_valid ? head_instr : 32'h0;
  assign bus.instr_pc       = head_valid ? head_pc : 32'h0;
  assign bus.imm_src        = head_valid ? imm_dec(head_instr[6:0]) : 3'b000;
endmodule
